// File: rtl/regfile_writeback.sv
// Write-side controller for the RV32I register file: merges ALU results and
// variable-latency load results onto the single write port and tracks pending loads.
module regfile_writeback #(
  parameter int LD_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            aluValid,
  input  logic [4:0]      aluRd,
  input  logic [XLEN-1:0] aluData,
  input  logic            ldIssue,
  input  logic [4:0]      ldIssueRd,
  output logic            issueStall,
  input  logic            ldValid,
  output logic            ldReady,
  input  logic [4:0]      ldRd,
  input  logic [XLEN-1:0] ldData,
  input  logic [4:0]      qAddr1,
  input  logic [4:0]      qAddr2,
  output logic            qBusy1,
  output logic            qBusy2,
  output logic            writeEn,
  output logic [4:0]      writeAddr,
  output logic [XLEN-1:0] dataIn,
  output logic            wawErr
);

  localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CNT_W = $clog2(LD_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LD_DEPTH);

  logic [4:0]      fifoRd   [LD_DEPTH];
  logic [XLEN-1:0] fifoData [LD_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count;

  logic [31:0] busy, busyNxt;

  logic            aluWr;
  logic            enq, deq;
  logic [4:0]      headRd;
  logic [XLEN-1:0] headData;
  logic            issueSet;

  logic            vld_p1;
  logic [4:0]      addr_p1;
  logic [XLEN-1:0] data_p1;
  logic            waw_p1;

  // Stage p0: arbitration, FIFO handshake and scoreboard next-state
  assign aluWr    = aluValid && (aluRd != 5'd0);
  assign ldReady  = (count < DEPTH_C);
  assign enq      = ldValid && ldReady;
  assign deq      = !aluWr && (count != '0);
  assign headRd   = fifoRd[rdPtr];
  assign headData = fifoData[rdPtr];

  assign issueStall = ldIssue && busy[ldIssueRd];
  assign issueSet   = ldIssue && (ldIssueRd != 5'd0) && !issueStall;

  assign qBusy1 = busy[qAddr1];
  assign qBusy2 = busy[qAddr2];

  // Clear first, then set, so an issue colliding with a drain keeps the bit.
  always_comb begin
    busyNxt = busy;
    if (deq && (headRd != 5'd0)) busyNxt[headRd] = 1'b0;
    if (issueSet) busyNxt[ldIssueRd] = 1'b1;
    busyNxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifoRd[wrPtr]   <= ldRd;
      fifoData[wrPtr] <= ldData;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      busy  <= '0;
    end else begin
      if (enq) wrPtr <= wrPtr + PTR_W'(1);
      if (deq) rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      busy  <= busyNxt;
    end
  end

  // Stage p1: registered register-file write port
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      waw_p1  <= 1'b0;
    end else begin
      if (aluWr) begin
        vld_p1  <= 1'b1;
        addr_p1 <= aluRd;
        data_p1 <= aluData;
      end else if (deq && (headRd != 5'd0)) begin
        vld_p1  <= 1'b1;
        addr_p1 <= headRd;
        data_p1 <= headData;
      end else begin
        vld_p1  <= 1'b0;
      end
      if (aluWr && busy[aluRd]) waw_p1 <= 1'b1;
    end
  end

  assign writeEn   = vld_p1;
  assign writeAddr = addr_p1;
  assign dataIn    = data_p1;
  assign wawErr    = waw_p1;

endmodule
